// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - display scan controller signal bundle
// Inputs come from the host side (master), outputs drive the LED digit matrix.
interface display_scan_ctrl_if;
  logic [15:0] digits;
  logic [3:0]  blink_en;
  logic [3:0]  dp_en;
  logic        disp_en;
  logic [3:0]  anode;
  logic [3:0]  bcd_out;
  logic        dp;
  logic [1:0]  digit_sel;

  modport master (
    output digits, blink_en, dp_en, disp_en,
    input  anode, bcd_out, dp, digit_sel
  );

  modport slave (
    input  digits, blink_en, dp_en, disp_en,
    output anode, bcd_out, dp, digit_sel
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit multiplexed seven-segment scan controller
// Outputs are registered from the pre-edge scan slot, so they lag digit_sel by one cycle.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                clk,
  input  logic                rst_n,
  display_scan_ctrl_if.slave  bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {SLOT0 = 2'd0, SLOT1 = 2'd1, SLOT2 = 2'd2, SLOT3 = 2'd3} slot_t;

  slot_t         scan_state;
  slot_t         scan_next;
  logic [PW-1:0] presc;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          slot_tick;
  logic          frame_done;

  logic [3:0]    anode_d;
  logic [3:0]    bcd_d;
  logic          dp_d;
  logic          blank;

  logic [3:0]    anode_q;
  logic [3:0]    bcd_q;
  logic          dp_q;

  assign slot_tick  = (presc == PW'(REFRESH_DIV - 1));
  assign frame_done = slot_tick && (scan_state == SLOT3);

  // Timing chain keeps running regardless of disp_en so blanking never shifts the scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc       <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      presc <= slot_tick ? '0 : presc + 1'b1;
      if (frame_done) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_state <= SLOT0;
    end else begin
      scan_state <= scan_next;
    end
  end

  always_comb begin
    scan_next = scan_state;
    if (slot_tick) begin
      unique case (scan_state)
        SLOT0:   scan_next = SLOT1;
        SLOT1:   scan_next = SLOT2;
        SLOT2:   scan_next = SLOT3;
        default: scan_next = SLOT0;
      endcase
    end
  end

  always_comb begin
    blank   = !bus.disp_en || (bus.blink_en[scan_state] && blink_phase);
    anode_d = blank ? 4'b1111 : ~(4'b0001 << scan_state);
    bcd_d   = bus.digits[{scan_state, 2'b00} +: 4];
    dp_d    = blank | ~bus.dp_en[scan_state];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode_q <= 4'b1111;
      bcd_q   <= 4'h0;
      dp_q    <= 1'b1;
    end else begin
      anode_q <= anode_d;
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.anode     = anode_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.dp        = dp_q;
  assign bus.digit_sel = scan_state;

endmodule
